// File: rtl/regfile_bypass_multi_pkg.sv
// Shared defaults, stage-entry type and select range helper for the bypassed register file.
// Latency: none (types and pure functions only).
// Backpressure: none; optional REGFILE_R0_ZERO_EN build macro is consumed by the files that import this.
package regfile_pkg;

    localparam int DATA_W_DEF   = 16;
    localparam int NUM_REGS_DEF = 8;
    localparam int NUM_RD_DEF   = 2;

    // Stage entries are sized for the largest legal configuration (64 registers,
    // 64-bit data); each instance only uses the low SEL_W / DATA_W bits.
    localparam int STAGE_SEL_MAX_W  = 6;
    localparam int STAGE_DATA_MAX_W = 64;

    typedef struct packed {
        logic                        valid;
        logic [STAGE_SEL_MAX_W-1:0]  sel;
        logic [STAGE_DATA_MAX_W-1:0] data;
    } stage_ent_t;

    // True when a register select addresses an existing register.
    function automatic logic sel_in_range(input logic [31:0] sel, input int unsigned nregs);
        return sel < nregs;
    endfunction

endpackage

// File: rtl/regfile_bypass_multi_if.sv
// Read/write bundle between the decode/commit stages and the bypassed register file.
// Latency: reads are combinational; writes land in a stage entry one edge later.
// Backpressure: none, every write is accepted; optional REGFILE_R0_ZERO_EN affects only the slave.
interface regfile_bypass_multi_if #(
    parameter int DATA_W   = 16,
    parameter int NUM_REGS = 8,
    parameter int NUM_RD   = 2,
    parameter int SEL_W    = $clog2(NUM_REGS)
);
    logic [NUM_RD*SEL_W-1:0]  readRegSel;
    logic [NUM_RD*DATA_W-1:0] readData;
    logic                     wr0En;
    logic [SEL_W-1:0]         wr0Sel;
    logic [DATA_W-1:0]        wr0Data;
    logic                     wr1En;
    logic [SEL_W-1:0]         wr1Sel;
    logic [DATA_W-1:0]        wr1Data;
    logic                     err;
    logic                     errSticky;

    modport master (
        output readRegSel, wr0En, wr0Sel, wr0Data, wr1En, wr1Sel, wr1Data,
        input  readData, err, errSticky
    );

    modport slave (
        input  readRegSel, wr0En, wr0Sel, wr0Data, wr1En, wr1Sel, wr1Data,
        output readData, err, errSticky
    );
endinterface

// File: rtl/regfile_bypass_multi_wr_stage.sv
// One write staging entry: captures an accepted write, presents it for commit the next cycle.
// Latency: 1 edge from write to valid entry; entry commits on the following edge.
// Backpressure: none; out-of-range, suppressed or (with REGFILE_R0_ZERO_EN) sel-0 writes are dropped.
module regfile_wr_stage
    import regfile_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int NUM_REGS = NUM_REGS_DEF,
    parameter int SEL_W    = $clog2(NUM_REGS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en_i,
    input  logic [SEL_W-1:0]  wr_sel_i,
    input  logic [DATA_W-1:0] wr_data_i,
    input  logic              suppress_i,
    output stage_ent_t        ent_o,
    output logic              commit_o
);

    stage_ent_t ent_d;
    stage_ent_t ent_q;

    // Next entry: reloaded every cycle, valid only for a write that will really land.
    always_comb begin
        ent_d       = '0;
        ent_d.valid = wr_en_i & ~suppress_i & sel_in_range(32'(wr_sel_i), NUM_REGS);
`ifdef REGFILE_R0_ZERO_EN
        if (wr_sel_i == '0) begin
            ent_d.valid = 1'b0;
        end
`endif
        ent_d.sel   = STAGE_SEL_MAX_W'(wr_sel_i);
        ent_d.data  = STAGE_DATA_MAX_W'(wr_data_i);
    end

    // Entry register; reset discards anything not yet committed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ent_q <= '0;
        end else begin
            ent_q <= ent_d;
        end
    end

    assign ent_o    = ent_q;
    assign commit_o = ent_q.valid;

endmodule

// File: rtl/regfile_bypass_multi.sv
// Parametrised 2-write, NUM_RD-read register file with write staging and full forwarding.
// Latency: reads zero-cycle combinational; writes commit two edges after presentation, hidden by bypass.
// Backpressure: none; REGFILE_R0_ZERO_EN makes register 0 read as zero and ignore writes.
module regfile_bypass_multi
    import regfile_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int NUM_REGS = NUM_REGS_DEF,
    parameter int NUM_RD   = NUM_RD_DEF
) (
    input  logic                   clk,
    input  logic                   rst,
    regfile_bypass_multi_if.slave  bus
);

    localparam int SEL_W = $clog2(NUM_REGS);

    logic [NUM_RD*SEL_W-1:0]  rd_sel_all;
    logic [NUM_RD*DATA_W-1:0] rd_data;
    logic                     wr0_en;
    logic [SEL_W-1:0]         wr0_sel;
    logic [DATA_W-1:0]        wr0_data;
    logic                     wr1_en;
    logic [SEL_W-1:0]         wr1_sel;
    logic [DATA_W-1:0]        wr1_data;

    assign rd_sel_all = bus.readRegSel;
    assign wr0_en     = bus.wr0En;
    assign wr0_sel    = bus.wr0Sel;
    assign wr0_data   = bus.wr0Data;
    assign wr1_en     = bus.wr1En;
    assign wr1_sel    = bus.wr1Sel;
    assign wr1_data   = bus.wr1Data;

    logic [DATA_W-1:0] mem_q [NUM_REGS];
    stage_ent_t        st0;
    stage_ent_t        st1;
    logic              commit0;
    logic              commit1;
    logic              suppress0;
    logic              err_c;
    logic              err_sticky_d;
    logic              err_sticky_q;

    // Port 1 wins a same-cycle collision, so port 0's write never stages.
    assign suppress0 = wr0_en & wr1_en & (wr0_sel == wr1_sel);

    regfile_wr_stage #(.DATA_W(DATA_W), .NUM_REGS(NUM_REGS), .SEL_W(SEL_W)) u_stage0 (
        .clk        (clk),
        .rst        (rst),
        .wr_en_i    (wr0_en),
        .wr_sel_i   (wr0_sel),
        .wr_data_i  (wr0_data),
        .suppress_i (suppress0),
        .ent_o      (st0),
        .commit_o   (commit0)
    );

    regfile_wr_stage #(.DATA_W(DATA_W), .NUM_REGS(NUM_REGS), .SEL_W(SEL_W)) u_stage1 (
        .clk        (clk),
        .rst        (rst),
        .wr_en_i    (wr1_en),
        .wr_sel_i   (wr1_sel),
        .wr_data_i  (wr1_data),
        .suppress_i (1'b0),
        .ent_o      (st1),
        .commit_o   (commit1)
    );

    // Upper stage bits beyond SEL_W/DATA_W are always zero here.
    logic unused_stage;
    assign unused_stage = ^{st0, st1};

    // Array commit from the stage entries; the two entries never share a register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (commit1 && st1.sel == STAGE_SEL_MAX_W'(i)) begin
                    mem_q[i] <= st1.data[DATA_W-1:0];
                end else if (commit0 && st0.sel == STAGE_SEL_MAX_W'(i)) begin
                    mem_q[i] <= st0.data[DATA_W-1:0];
                end
            end
        end
    end

    // Newest-first lookup: current wr1, current wr0, stage1, stage0, array.
    function automatic logic [DATA_W-1:0] fwd_read(input logic [SEL_W-1:0] rs);
        logic [DATA_W-1:0] v;
        v = '0;
        if (!sel_in_range(32'(rs), NUM_REGS)) begin
            v = '0;
        end else if (wr1_en && wr1_sel == rs) begin
            v = wr1_data;
        end else if (wr0_en && wr0_sel == rs) begin
            v = wr0_data;
        end else if (st1.valid && st1.sel == STAGE_SEL_MAX_W'(rs)) begin
            v = st1.data[DATA_W-1:0];
        end else if (st0.valid && st0.sel == STAGE_SEL_MAX_W'(rs)) begin
            v = st0.data[DATA_W-1:0];
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (rs == SEL_W'(i)) begin
                    v = mem_q[i];
                end
            end
        end
`ifdef REGFILE_R0_ZERO_EN
        if (rs == '0) begin
            v = '0;
        end
`endif
        return v;
    endfunction

    // Read ports; held at zero while reset is asserted so in-flight writes cannot leak.
    always_comb begin
        rd_data = '0;
        for (int k = 0; k < NUM_RD; k++) begin
            rd_data[k*DATA_W +: DATA_W] = rst ? '0 : fwd_read(rd_sel_all[k*SEL_W +: SEL_W]);
        end
    end

    assign bus.readData = rd_data;

    // Illegal-access detect: out-of-range reads or enabled writes, plus unknown controls in simulation.
    always_comb begin
        err_c = 1'b0;
        for (int k = 0; k < NUM_RD; k++) begin
            if (!sel_in_range(32'(rd_sel_all[k*SEL_W +: SEL_W]), NUM_REGS)) begin
                err_c = 1'b1;
            end
        end
        if (wr0_en && !sel_in_range(32'(wr0_sel), NUM_REGS)) begin
            err_c = 1'b1;
        end
        if (wr1_en && !sel_in_range(32'(wr1_sel), NUM_REGS)) begin
            err_c = 1'b1;
        end
`ifndef SYNTHESIS
        if ($isunknown({rd_sel_all, wr0_en, wr0_sel, wr1_en, wr1_sel})) begin
            err_c = 1'b1;
        end
`endif
    end

    assign err_sticky_d = err_sticky_q | err_c;

    // Sticky error flag, cleared only by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_sticky_q <= 1'b0;
        end else begin
            err_sticky_q <= err_sticky_d;
        end
    end

    assign bus.err       = err_c;
    assign bus.errSticky = err_sticky_q;

endmodule

// File: tb/tb_regfile_bypass_multi.sv
// Self-checking bench for regfile_bypass_multi (6 registers, 2 read ports, 16-bit data).
// Directed table plus hand sequences, then random traffic against an architectural model.
// Honours REGFILE_R0_ZERO_EN in its model and adds an r0 sequence when defined.
module tb_regfile_bypass_multi;

    localparam int DW  = 16;
    localparam int NR  = 6;
    localparam int NRD = 2;

    logic clk;
    logic rst;

    regfile_bypass_multi_if #(.DATA_W(DW), .NUM_REGS(NR), .NUM_RD(NRD)) bus ();

    regfile_bypass_multi #(.DATA_W(DW), .NUM_REGS(NR), .NUM_RD(NRD)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    // Architectural view: a write is visible the moment it is presented.
    logic [DW-1:0] model [NR];
    logic          model_sticky;

    typedef struct {
        logic [2:0]  rs0;
        logic [2:0]  rs1;
        logic        w0e;
        logic [2:0]  w0s;
        logic [15:0] w0d;
        logic        w1e;
        logic [2:0]  w1s;
        logic [15:0] w1d;
        logic [15:0] e0;
        logic [15:0] e1;
        logic        eerr;
    } vec_t;

    vec_t tbl [16];

    task automatic model_clear();
        for (int i = 0; i < NR; i++) model[i] = '0;
        model_sticky = 1'b0;
    endtask

    function automatic logic writable(input logic [2:0] s);
        logic ok;
        ok = (s < NR);
`ifdef REGFILE_R0_ZERO_EN
        if (s == 3'd0) ok = 1'b0;
`endif
        return ok;
    endfunction

    function automatic logic [15:0] model_rd(input logic [2:0] s);
        logic [15:0] v;
        if (s >= NR) v = '0;
        else if (bus.wr1En && bus.wr1Sel == s) v = bus.wr1Data;
        else if (bus.wr0En && bus.wr0Sel == s) v = bus.wr0Data;
        else v = model[s];
`ifdef REGFILE_R0_ZERO_EN
        if (s == 3'd0) v = '0;
`endif
        return v;
    endfunction

    function automatic logic model_err();
        logic [2:0] r0s;
        logic [2:0] r1s;
        r0s = bus.readRegSel[2:0];
        r1s = bus.readRegSel[5:3];
        return (r0s >= NR) || (r1s >= NR) ||
               (bus.wr0En && bus.wr0Sel >= NR) || (bus.wr1En && bus.wr1Sel >= NR);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic [2:0] rs0, input logic [2:0] rs1,
                         input logic w0e, input logic [2:0] w0s, input logic [15:0] w0d,
                         input logic w1e, input logic [2:0] w1s, input logic [15:0] w1d);
        bus.readRegSel = {rs1, rs0};
        bus.wr0En      = w0e;
        bus.wr0Sel     = w0s;
        bus.wr0Data    = w0d;
        bus.wr1En      = w1e;
        bus.wr1Sel     = w1s;
        bus.wr1Data    = w1d;
        @(negedge clk);
    endtask

    task automatic idle();
        drive(3'd0, 3'd0, 1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 16'h0);
    endtask

    // Compare both read ports and both error flags against the model.
    task automatic check_model(input string tag);
        check({tag, "_rd0"}, 32'(bus.readData[15:0]),  32'(model_rd(bus.readRegSel[2:0])));
        check({tag, "_rd1"}, 32'(bus.readData[31:16]), 32'(model_rd(bus.readRegSel[5:3])));
        check({tag, "_err"}, 32'(bus.err), 32'(model_err()));
        check({tag, "_sticky"}, 32'(bus.errSticky), 32'(model_sticky));
    endtask

    // Retire the cycle in the model, then cross the clock edge.
    task automatic tick();
        if (bus.wr0En && writable(bus.wr0Sel) && !(bus.wr1En && bus.wr1Sel == bus.wr0Sel))
            model[bus.wr0Sel] = bus.wr0Data;
        if (bus.wr1En && writable(bus.wr1Sel))
            model[bus.wr1Sel] = bus.wr1Data;
        model_sticky = model_sticky | model_err();
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mkv(input logic [2:0] rs0, input logic [2:0] rs1,
                                 input logic w0e, input logic [2:0] w0s, input logic [15:0] w0d,
                                 input logic w1e, input logic [2:0] w1s, input logic [15:0] w1d,
                                 input logic [15:0] e0, input logic [15:0] e1, input logic eerr);
        vec_t v;
        v.rs0 = rs0; v.rs1 = rs1; v.w0e = w0e; v.w0s = w0s; v.w0d = w0d;
        v.w1e = w1e; v.w1s = w1s; v.w1d = w1d; v.e0 = e0; v.e1 = e1; v.eerr = eerr;
        return v;
    endfunction

    initial begin
        tbl[0]  = mkv(3'd3, 3'd4, 1'b1, 3'd3, 16'hBEEF, 1'b0, 3'd0, 16'h0000, 16'hBEEF, 16'h0000, 1'b0);
        tbl[1]  = mkv(3'd3, 3'd3, 1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 16'h0000, 16'hBEEF, 16'hBEEF, 1'b0);
        tbl[2]  = mkv(3'd3, 3'd0, 1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 16'h0000, 16'hBEEF, 16'h0000, 1'b0);
        tbl[3]  = mkv(3'd5, 3'd3, 1'b1, 3'd5, 16'h1111, 1'b1, 3'd5, 16'h2222, 16'h2222, 16'hBEEF, 1'b0);
        tbl[4]  = mkv(3'd5, 3'd5, 1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 16'h0000, 16'h2222, 16'h2222, 1'b0);
        tbl[5]  = mkv(3'd5, 3'd1, 1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 16'h0000, 16'h2222, 16'h0000, 1'b0);
        tbl[6]  = mkv(3'd2, 3'd5, 1'b1, 3'd2, 16'h0001, 1'b0, 3'd0, 16'h0000, 16'h0001, 16'h2222, 1'b0);
        tbl[7]  = mkv(3'd2, 3'd2, 1'b1, 3'd2, 16'h0002, 1'b0, 3'd0, 16'h0000, 16'h0002, 16'h0002, 1'b0);
        tbl[8]  = mkv(3'd2, 3'd3, 1'b0, 3'd0, 16'h0000, 1'b1, 3'd2, 16'h0003, 16'h0003, 16'hBEEF, 1'b0);
        tbl[9]  = mkv(3'd2, 3'd2, 1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 16'h0000, 16'h0003, 16'h0003, 1'b0);
        tbl[10] = mkv(3'd2, 3'd5, 1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 16'h0000, 16'h0003, 16'h2222, 1'b0);
        tbl[11] = mkv(3'd7, 3'd2, 1'b0, 3'd0, 16'h0000, 1'b1, 3'd6, 16'hAAAA, 16'h0000, 16'h0003, 1'b1);
        tbl[12] = mkv(3'd6, 3'd5, 1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 16'h0000, 16'h0000, 16'h2222, 1'b1);
        tbl[13] = mkv(3'd0, 3'd1, 1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 16'h0000, 16'h0000, 16'h0000, 1'b0);
        tbl[14] = mkv(3'd1, 3'd4, 1'b1, 3'd6, 16'h5555, 1'b0, 3'd0, 16'h0000, 16'h0000, 16'h0000, 1'b1);
        tbl[15] = mkv(3'd0, 3'd1, 1'b0, 3'd7, 16'h6666, 1'b0, 3'd0, 16'h0000, 16'h0000, 16'h0000, 1'b0);

        model_clear();
        rst = 1'b0;
        bus.readRegSel = '0;
        bus.wr0En = 1'b0; bus.wr0Sel = '0; bus.wr0Data = '0;
        bus.wr1En = 1'b0; bus.wr1Sel = '0; bus.wr1Data = '0;
        #1 rst = 1'b1;

        // While reset is held, a current-cycle write must not show on the read port.
        drive(3'd3, 3'd4, 1'b1, 3'd3, 16'h1234, 1'b0, 3'd0, 16'h0);
        check("rst_hold_rd0", 32'(bus.readData[15:0]), 32'h0);
        @(posedge clk); #1;
        bus.wr0En = 1'b0;
        #1 rst = 1'b0;

        // Every register reads zero after reset, no errors.
        for (int i = 0; i < NR; i++) begin
            drive(3'(i), 3'(NR - 1 - i), 1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 16'h0);
            check("rst_rd0", 32'(bus.readData[15:0]), 32'h0);
            check("rst_rd1", 32'(bus.readData[31:16]), 32'h0);
            check("rst_err", 32'(bus.err), 32'h0);
            check("rst_sticky", 32'(bus.errSticky), 32'h0);
            tick();
        end

        // Directed table: same-cycle, stage and array reads; collisions; out-of-range.
        for (int t = 0; t < 16; t++) begin
            drive(tbl[t].rs0, tbl[t].rs1, tbl[t].w0e, tbl[t].w0s, tbl[t].w0d,
                  tbl[t].w1e, tbl[t].w1s, tbl[t].w1d);
            check($sformatf("tbl%0d_rd0", t), 32'(bus.readData[15:0]),  32'(tbl[t].e0));
            check($sformatf("tbl%0d_rd1", t), 32'(bus.readData[31:16]), 32'(tbl[t].e1));
            check($sformatf("tbl%0d_err", t), 32'(bus.err), 32'(tbl[t].eerr));
            check($sformatf("tbl%0d_sticky", t), 32'(bus.errSticky), 32'(model_sticky));
            tick();
        end
        check("sticky_after_oor", 32'(bus.errSticky), 32'h1);

        // Staged write discarded by a reset pulse before it commits.
        drive(3'd4, 3'd3, 1'b1, 3'd4, 16'h7777, 1'b0, 3'd0, 16'h0);
        check("mid_rst_same_cycle", 32'(bus.readData[15:0]), 32'h7777);
        tick();
        bus.wr0En = 1'b0;
        bus.wr1En = 1'b1; bus.wr1Sel = 3'd4; bus.wr1Data = 16'h9999;
        bus.readRegSel = {3'd3, 3'd4};
        #1 rst = 1'b1;
        #1 check("mid_rst_hold_rd0", 32'(bus.readData[15:0]), 32'h0);
        check("mid_rst_hold_rd1", 32'(bus.readData[31:16]), 32'h0);
        bus.wr1En = 1'b0;
        #1 rst = 1'b0;
        model_clear();
        for (int c = 0; c < 3; c++) begin
            drive(3'd4, 3'd3, 1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 16'h0);
            check("mid_rst_r4", 32'(bus.readData[15:0]), 32'h0);
            check("mid_rst_r3", 32'(bus.readData[31:16]), 32'h0);
            check("mid_rst_sticky", 32'(bus.errSticky), 32'h0);
            tick();
        end

`ifdef REGFILE_R0_ZERO_EN
        // Register 0 stays zero even against same-cycle writes on both ports.
        drive(3'd0, 3'd0, 1'b1, 3'd0, 16'hFFFF, 1'b1, 3'd0, 16'hEEEE);
        check("r0_same_cycle", 32'(bus.readData[15:0]), 32'h0);
        check("r0_err", 32'(bus.err), 32'h0);
        tick();
        for (int c = 0; c < 2; c++) begin
            idle();
            check("r0_later", 32'(bus.readData[15:0]), 32'h0);
            tick();
        end
`endif

        // Random traffic against the architectural model, with occasional reset pulses.
        for (int c = 0; c < 400; c++) begin
            logic [2:0] rs0, rs1, w0s, w1s;
            if (c % 100 == 50) begin
                idle();
                tick();
                #1 rst = 1'b1;
                #1 rst = 1'b0;
                model_clear();
            end
            rs0 = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(6, 7)) : 3'($urandom_range(0, 5));
            rs1 = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(6, 7)) : 3'($urandom_range(0, 5));
            w0s = ($urandom_range(0, 15) == 0) ? 3'($urandom_range(6, 7)) : 3'($urandom_range(0, 5));
            w1s = ($urandom_range(0, 3) == 0) ? w0s : 3'($urandom_range(0, 5));
            drive(rs0, rs1, 1'($urandom_range(0, 1)), w0s, 16'($urandom),
                  1'($urandom_range(0, 1)), w1s, 16'($urandom));
            check_model($sformatf("rnd%0d", c));
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
